instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of each lockstep core. It issues word requests to instruction memory from a local PC and buffers the returned words with their PCs in a small in-order queue. It presents one 32-bit instruction per valid/ready handshake to the instruction field parser and decode stage. It also handles branch/jump redirects, stops fetching while an ask-for-lock (AFL) instruction waits for a grant, and traps misaligned redirect targets.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, queue entries and maximum requests in flight combined; power of two, 2..8
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant
- imem_rdata  in  32  response word
- redirect_valid  in  1  taken branch/JAL/JALR from execute
- redirect_pc  in  32  redirect target
- lock_grant  in  1  lock arbiter grant for a pending AFL
- instr_valid  out  1  instruction/instr_pc valid
- instr_ready  in  1  downstream accepts
- instruction  out  32  queue head word; 0 when !instr_valid
- instr_pc  out  32  PC of the head word; 0 when !instr_valid
- fetch_fault  out  1  sticky misaligned-redirect flag

## Operation
- States: FETCH, WAIT_LOCK, FAULT. Reset state is FETCH, with fetch_pc=RESET_PC and the queue, outstanding count and discard count all cleared.
- Credit rule: `imem_req = (state==FETCH) & !redirect_valid & (outstanding + count < DEPTH)`. imem_addr = fetch_pc. This is combinational.
- On `imem_req & imem_gnt`:
  - fetch_pc += 4, wrapping mod 2^32.
  - outstanding increments.
  - The issued PC is pushed to a PC-tag FIFO.
- On imem_rvalid:
  - If discard > 0, the response is dropped and discard decrements.
  - Otherwise {imem_rdata, tag} is pushed to the queue.
  - Either way, outstanding decrements.
  - The credit rule guarantees the queue never overflows.
- Pop on `instr_valid & instr_ready`. Push and pop in the same cycle leave count unchanged.
- AFL handling:
  - When a pushed word has opcode 7'b0100000 (AFL), the state moves FETCH→WAIT_LOCK. No new requests issue; in-flight responses still enqueue.
  - WAIT_LOCK→FETCH on the first cycle lock_grant=1.
  - NML (7'b1000000) passes through with no effect.
- Redirect (redirect_valid=1) takes priority over every other event in the same cycle:
  - If redirect_pc[1:0]≠0: state→FAULT and fetch_fault→1.
  - Otherwise: state→FETCH from any non-FAULT state, and fetch_pc←redirect_pc.
  - The queue is flushed and the tag FIFO cleared.
  - discard ← outstanding − (imem_rvalid ? 1 : 0). Any response in the redirect cycle is also dropped.
  - Outstanding is unchanged, so credit stays consumed until the stale responses drain.
  - A handshake in the redirect cycle still counts as consumed.
- FAULT: no requests, instr_valid=0, ignores everything except rst. Only rst clears fetch_fault.
- rst mid-operation clears everything. Responses to pre-reset requests must not be delivered after reset; the memory model is reset together with this block.

## Timing
- Reset outputs: imem_req=0 while rst=1, imem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, fetch_fault=0.
- First request: imem_req=1 in the first cycle with rst=0.
- Latency: a response in cycle N gives instr_valid=1 in cycle N+1, because the queue is registered. With a 1-cycle memory, grant at T gives the instruction at T+2.
- Steady state: 1 instruction/cycle is sustainable with a 1-cycle memory and DEPTH≥2.
- Redirect at cycle R: instr_valid=0 at R+1. The request for redirect_pc issues at R+1 if credit allows.
- Lock: the AFL becomes visible at N+1. The next request issues in the cycle after lock_grant is first seen high.
- instruction and instr_pc stay stable while `instr_valid & !instr_ready`.

## Test plan
- Reset, 1-cycle memory returning 32'h00000013+addr, instr_ready=1 → PCs 0,4,8,… on consecutive cycles; first instr_valid 2 cycles after the first grant.
- instr_ready=0 for 5 cycles → at most DEPTH requests granted; head stays PC 0 and never changes; no response lost after release.
- 3-cycle memory with 2 requests in flight, redirect_pc=32'h100 → both stale responses dropped; next delivered instr_pc=32'h100.
- Fetched word 32'h00000020 (AFL) at PC 8 → imem_req=0 until lock_grant; the next request (PC 12) issues the cycle after the grant.
- redirect_pc=32'h102 → fetch_fault=1, imem_req=0 and instr_valid=0 thereafter; rst clears it and fetch restarts at RESET_PC.
- Redirect in the same cycle as imem_rvalid and a handshake → the handshaked word counts as consumed, the response is dropped, and no duplicate or stale instruction appears.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues word requests from a local PC, queues returned words with
// their PCs, and hands one instruction per valid/ready handshake to decode.
// Handles redirects (with stale-response discard), AFL lock stalls and
// misaligned-redirect traps.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        lock_grant,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [1:0] ST_FETCH     = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_FAULT     = 2'd2;

  localparam logic [6:0] OPC_AFL = 7'b0100000;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic [PTR_W-1:0] q_rd_q, q_rd_d;
  logic [PTR_W-1:0] q_wr_q, q_wr_d;
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d;
  logic [PTR_W-1:0] tag_wr_q, tag_wr_d;

  logic [31:0] q_data_q [DEPTH];
  logic [31:0] q_data_d [DEPTH];
  logic [31:0] q_pc_q   [DEPTH];
  logic [31:0] q_pc_d   [DEPTH];
  logic [31:0] tag_q    [DEPTH];
  logic [31:0] tag_d    [DEPTH];

  logic credit_ok;
  logic grant;
  logic pop;
  logic push;

  // Credit covers both queued words and requests still in flight, so the queue cannot overflow.
  assign credit_ok   = ({1'b0, out_q} + {1'b0, q_cnt_q}) < SUM_W'(DEPTH);
  assign imem_req    = !rst && (state_q == ST_FETCH) && !redirect_valid && credit_ok;
  assign imem_addr   = fetch_pc_q;
  assign grant       = imem_req && imem_gnt;
  assign instr_valid = (state_q != ST_FAULT) && (q_cnt_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign instruction = instr_valid ? q_data_q[q_rd_q] : 32'h0;
  assign instr_pc    = instr_valid ? q_pc_q[q_rd_q]   : 32'h0;
  assign fetch_fault = fault_q;

  // Next-state: redirect wins over everything; otherwise issue, enqueue, dequeue and lock tracking.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    out_d      = out_q;
    disc_d     = disc_q;
    q_cnt_d    = q_cnt_q;
    q_rd_d     = q_rd_q;
    q_wr_d     = q_wr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    q_data_d   = q_data_q;
    q_pc_d     = q_pc_q;
    tag_d      = tag_q;
    push       = 1'b0;

    if (state_q != ST_FAULT) begin
      if (redirect_valid) begin
        q_cnt_d  = '0;
        q_rd_d   = '0;
        q_wr_d   = '0;
        tag_rd_d = '0;
        tag_wr_d = '0;
        // Every request still in flight after this cycle returns a stale word.
        out_d    = out_q - CNT_W'(imem_rvalid);
        disc_d   = out_d;
        if (redirect_pc[1:0] != 2'b00) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          state_d    = ST_FETCH;
          fetch_pc_d = redirect_pc;
        end
      end else begin
        out_d = out_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
        if (grant) begin
          fetch_pc_d      = fetch_pc_q + 32'd4;
          tag_d[tag_wr_q] = fetch_pc_q;
          tag_wr_d        = tag_wr_q + PTR_W'(1);
        end
        if (imem_rvalid) begin
          if (disc_q != '0) begin
            disc_d = disc_q - CNT_W'(1);
          end else begin
            push             = 1'b1;
            q_data_d[q_wr_q] = imem_rdata;
            q_pc_d[q_wr_q]   = tag_q[tag_rd_q];
            q_wr_d           = q_wr_q + PTR_W'(1);
            tag_rd_d         = tag_rd_q + PTR_W'(1);
          end
        end
        if (pop) begin
          q_rd_d = q_rd_q + PTR_W'(1);
        end
        q_cnt_d = q_cnt_q + CNT_W'(push) - CNT_W'(pop);
        if ((state_q == ST_WAIT_LOCK) && lock_grant) begin
          state_d = ST_FETCH;
        end
        if (push && (imem_rdata[6:0] == OPC_AFL)) begin
          state_d = ST_WAIT_LOCK;
        end
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
      out_q      <= '0;
      disc_q     <= '0;
      q_cnt_q    <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      q_cnt_q    <= q_cnt_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Queue and tag storage; contents are only meaningful where the pointers say so.
  always_ff @(posedge clk) begin
    q_data_q <= q_data_d;
    q_pc_q   <= q_pc_d;
    tag_q    <= tag_d;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with an in-order fixed-latency memory model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        lock_grant;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .lock_grant     (lock_grant),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int n_grant = 0;
  logic [31:0] afl_addr = 32'hFFFF_FFFF;

  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [31:0] got_pc  [$];
  logic [31:0] got_ins [$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == afl_addr) ? 32'h0000_0020 : 32'h0000_0013 + a;
  endfunction

  // Record grants and delivered instructions mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst && imem_req && imem_gnt) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + lat);
      n_grant++;
    end
    if (instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_ins.push_back(instruction);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic lg, input logic gnt);
    tick();
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    lock_grant     = lg;
    imem_gnt       = gnt;
    #1;
  endtask

  task automatic step_d();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mq_addr.delete();
    mq_due.delete();
    step_d();
    chk_eq("rst_req", imem_req, 32'd0);
    chk_eq("rst_addr", imem_addr, 32'h0);
    chk_eq("rst_valid", instr_valid, 32'd0);
    chk_eq("rst_instr", instruction, 32'h0);
    chk_eq("rst_pc", instr_pc, 32'h0);
    chk_eq("rst_fault", fetch_fault, 32'd0);
    step_d();
    rst = 1'b0;
    cyc = 0;
    got_pc.delete();
    got_ins.delete();
    #1;
  endtask

  task automatic run_until(input int n, input int bound);
    for (int i = 0; i < bound && got_pc.size() < n; i++) step_d();
  endtask

  initial begin
    int g0;
    logic [31:0] exp_pc [5];

    rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; lock_grant = 1'b0; instr_ready = 1'b1;

    // Streaming with a 1-cycle memory.
    lat = 1; afl_addr = 32'hFFFF_FFFF;
    do_reset();
    chk_eq("t1_req_c0", imem_req, 32'd1);
    chk_eq("t1_addr_c0", imem_addr, 32'h0);
    chk_eq("t1_valid_c0", instr_valid, 32'd0);
    step_d();
    chk_eq("t1_valid_c1", instr_valid, 32'd0);
    chk_eq("t1_addr_c1", imem_addr, 32'h4);
    for (int k = 2; k < 8; k++) begin
      step_d();
      chk_eq("t1_valid", instr_valid, 32'd1);
      chk_eq("t1_pc", instr_pc, 32'(4 * (k - 2)));
      chk_eq("t1_ins", instruction, 32'h13 + 32'(4 * (k - 2)));
    end

    // Backpressure: ready low for cycles 0..4.
    do_reset();
    instr_ready = 1'b0;
    g0 = n_grant;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 2; k < 5; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_eq("t2_head_valid", instr_valid, 32'd1);
      chk_eq("t2_head_pc", instr_pc, 32'h0);
    end
    step_d();
    chk_eq("t2_grants", 32'(n_grant - g0), 32'd4);
    chk_eq("t2_req_full", imem_req, 32'd0);
    chk_eq("t2_head_pc_c5", instr_pc, 32'h0);
    run_until(6, 30);
    chk_eq("t2_count", 32'(got_pc.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_pc.size(); i++) begin
      chk_eq("t2_seq_pc", got_pc[i], 32'(4 * i));
      chk_eq("t2_seq_ins", got_ins[i], 32'h13 + 32'(4 * i));
    end

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3;
    do_reset();
    step_d();
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b1);
    chk_eq("t3_req_redir", imem_req, 32'd0);
    step_d();
    chk_eq("t3_valid_r1", instr_valid, 32'd0);
    chk_eq("t3_req_r1", imem_req, 32'd1);
    chk_eq("t3_addr_r1", imem_addr, 32'h100);
    run_until(3, 40);
    chk_eq("t3_count", 32'(got_pc.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
      chk_eq("t3_seq_pc", got_pc[i], 32'h100 + 32'(4 * i));
      chk_eq("t3_seq_ins", got_ins[i], 32'h113 + 32'(4 * i));
    end

    // AFL at PC 8; PC 12 request refused so it becomes the post-grant request.
    lat = 1; afl_addr = 32'h8;
    do_reset();
    step_d();
    step_d();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_eq("t4_req_c3", imem_req, 32'd1);
    chk_eq("t4_addr_c3", imem_addr, 32'hC);
    step_d();
    chk_eq("t4_afl_valid", instr_valid, 32'd1);
    chk_eq("t4_afl_pc", instr_pc, 32'h8);
    chk_eq("t4_afl_ins", instruction, 32'h20);
    chk_eq("t4_req_c4", imem_req, 32'd0);
    step_d();
    chk_eq("t4_req_c5", imem_req, 32'd0);
    step_d();
    chk_eq("t4_req_c6", imem_req, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_eq("t4_req_grant", imem_req, 32'd0);
    step_d();
    chk_eq("t4_req_after", imem_req, 32'd1);
    chk_eq("t4_addr_after", imem_addr, 32'hC);
    step_d();
    step_d();
    chk_eq("t4_next_valid", instr_valid, 32'd1);
    chk_eq("t4_next_pc", instr_pc, 32'hC);
    afl_addr = 32'hFFFF_FFFF;

    // Misaligned redirect traps; only reset recovers.
    lat = 1;
    do_reset();
    step_d();
    step_d();
    step(1'b1, 1'b1, 32'h102, 1'b0, 1'b1);
    step_d();
    chk_eq("t5_fault", fetch_fault, 32'd1);
    chk_eq("t5_req", imem_req, 32'd0);
    chk_eq("t5_valid", instr_valid, 32'd0);
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b1);
    step_d();
    chk_eq("t5_fault_hold", fetch_fault, 32'd1);
    chk_eq("t5_req_hold", imem_req, 32'd0);
    chk_eq("t5_valid_hold", instr_valid, 32'd0);
    do_reset();
    chk_eq("t5_restart_req", imem_req, 32'd1);
    chk_eq("t5_restart_addr", imem_addr, 32'h0);
    chk_eq("t5_restart_fault", fetch_fault, 32'd0);

    // Redirect coinciding with a response and a handshake.
    do_reset();
    step_d();
    step_d();
    step_d();
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b1);
    chk_eq("t6_hs_valid", instr_valid, 32'd1);
    chk_eq("t6_hs_pc", instr_pc, 32'h8);
    step_d();
    chk_eq("t6_valid_r1", instr_valid, 32'd0);
    chk_eq("t6_req_r1", imem_req, 32'd1);
    chk_eq("t6_addr_r1", imem_addr, 32'h200);
    run_until(5, 30);
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    exp_pc[3] = 32'h200; exp_pc[4] = 32'h204;
    chk_eq("t6_count", 32'(got_pc.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_pc.size(); i++) begin
      chk_eq("t6_seq_pc", got_pc[i], exp_pc[i]);
      chk_eq("t6_seq_ins", got_ins[i], 32'h13 + exp_pc[i]);
    end
    step_d();
    step_d();
    chk_eq("t6_no_extra", 32'(got_pc.size()), 32'd7);
    chk_eq("t6_pc6", (got_pc.size() > 6) ? got_pc[6] : 32'hFFFF_FFFF, 32'h20C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
